// File: rtl/mux_arb_nto1_reg_if.sv
// Handshake bundle for mux_arb_nto1_reg: CHANNELS valid/ready sources in,
// one registered valid/ready word out.
interface mux_arb_nto1_reg_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/mux_arb_nto1_reg.sv
// N:1 arbitrated mux with a registered output stage.
// ARB_MUX_RR_EN selects round-robin; default is fixed priority (lowest index).
module mux_arb_nto1_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_arb_nto1_reg_if.slave     bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                load_en;
    logic                any_req;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;

`ifdef ARB_MUX_RR_EN
    logic [SEL_W-1:0]    last_q, last_d;
    logic                hi_found;

    // Search above the last grant first, then wrap to the low indices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        hi_found  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_valid[i] && (i > int'(last_q)) && !hi_found) begin
                hi_found  = 1'b1;
                any_req   = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_valid[i] && !any_req) begin
                any_req   = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_valid[i] && !any_req) begin
                any_req   = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end
`endif

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef ARB_MUX_RR_EN
        last_d      = last_q;
`endif
        if (load_en) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_sel_d   = grant_idx;
`ifdef ARB_MUX_RR_EN
                last_d      = grant_idx;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef ARB_MUX_RR_EN
            last_q      <= SEL_W'(CHANNELS-1);
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef ARB_MUX_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.in_ready  = rst_n ? (grant & {CHANNELS{load_en}}) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_arb_nto1_reg.sv
// Bench for mux_arb_nto1_reg: a 4-channel and a 3-channel instance checked
// every cycle against a queue-free arithmetic model, plus literal checks.
module tb_mux_arb_nto1_reg;
`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_arb_nto1_reg_if #(.WIDTH(32), .CHANNELS(4)) b4 ();
    mux_arb_nto1_reg_if #(.WIDTH(32), .CHANNELS(3)) b3 ();

    mux_arb_nto1_reg #(.WIDTH(32), .CHANNELS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));
    mux_arb_nto1_reg #(.WIDTH(32), .CHANNELS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3));

    logic [3:0]  vld [2];
    logic [31:0] dat [2][4];
    logic        ordy [2];

    assign b4.in_valid  = vld[0];
    assign b4.in_data   = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    assign b4.out_ready = ordy[0];
    assign b3.in_valid  = vld[1][2:0];
    assign b3.in_data   = {dat[1][2], dat[1][1], dat[1][0]};
    assign b3.out_ready = ordy[1];

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    bit          mv  [2];
    logic [31:0] md  [2];
    int          ms  [2];
    int          ptr [2];
    int          nch [2] = '{4, 3};
    logic [3:0]  acc [2];

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t got %h want %h",
                     nm, inst, $time, act, exp);
        end
    endtask

    // Priority winner: first valid channel after the pointer, wrapping.
    function automatic int pick(input int i);
        int p = RR ? ptr[i] : nch[i] - 1;
        for (int k = 1; k <= nch[i]; k++) begin
            int c = (p + k) % nch[i];
            if (vld[i][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(input int i);
        int g;
        if (!rst_n) return 4'b0;
        g = pick(i);
        if (g < 0 || !(!mv[i] || ordy[i])) return 4'b0;
        return 4'(1 << g);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int g;
            acc[i] = vld[i] & exp_rdy(i);
            if (!rst_n) begin
                mv[i]  = 1'b0;
                md[i]  = '0;
                ms[i]  = 0;
                ptr[i] = nch[i] - 1;
            end else if (!mv[i] || ordy[i]) begin
                g = pick(i);
                if (g >= 0) begin
                    mv[i] = 1'b1;
                    md[i] = dat[i][g];
                    ms[i] = g;
                    if (RR) ptr[i] = g;
                end else begin
                    mv[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy", 0, 32'(b4.in_ready), 32'(exp_rdy(0)));
            chk("ov", 0, 32'(b4.out_valid), 32'(mv[0]));
            chk("od", 0, b4.out_data, md[0]);
            chk("os", 0, 32'(b4.out_sel), 32'(ms[0]));
            chk("rdy", 1, 32'(b3.in_ready), 32'(exp_rdy(1)));
            chk("ov", 1, 32'(b3.out_valid), 32'(mv[1]));
            chk("od", 1, b3.out_data, md[1]);
            chk("os", 1, 32'(b3.out_sel), 32'(ms[1]));
            chk("sel_rng", 1, 32'(b3.out_sel < 2'd3), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input logic [3:0] v);
        vld[0] = v;
        vld[1] = v & 4'h7;
    endtask

    task automatic setd(input int c, input logic [31:0] d);
        dat[0][c] = d;
        dat[1][c] = d;
    endtask

    task automatic setr(input logic r);
        ordy[0] = r;
        ordy[1] = r;
    endtask

    initial begin
        rst_n = 1'b0;
        setv(4'hF);
        setr(1'b1);
        for (int c = 0; c < 4; c++) setd(c, 32'h1000_0000 + c);
        step();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 0, 32'(b4.in_ready), 32'h0);
        chk("rst_ov", 0, 32'(b4.out_valid), 32'h0);
        chk("rst_od", 0, b4.out_data, 32'h0);
        chk("rst_os", 0, 32'(b4.out_sel), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 0, 32'(b4.in_ready), 32'h1);
        chk("first_grant", 1, 32'(b3.in_ready), 32'h1);

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("cont_sel", 0, 32'(b4.out_sel), RR ? 32'(k % 4) : 32'h0);
            chk("cont_sel", 1, 32'(b3.out_sel), RR ? 32'(k % 3) : 32'h0);
        end

        step();
        setv(4'b0100);
        setd(2, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("single_rdy", 0, 32'(b4.in_ready), 32'h4);
        chk("single_rdy", 1, 32'(b3.in_ready), 32'h4);
        @(negedge clk);
        chk("single_ov", 0, 32'(b4.out_valid), 32'h1);
        chk("single_od", 0, b4.out_data, 32'hDEAD_BEEF);
        chk("single_os", 0, 32'(b4.out_sel), 32'h2);

        step();
        setv(4'b0010);
        setd(1, 32'h1111_0001);
        step();
        setv(4'b1010);
        setd(1, 32'h2222_0002);
        setd(3, 32'h3333_0003);
        setr(1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_od", 0, b4.out_data, 32'h1111_0001);
            chk("bp_rdy", 0, 32'(b4.in_ready), 32'h0);
            step();
        end
        setr(1'b1);
        @(negedge clk);
        chk("drain_rdy", 0, 32'(b4.in_ready), RR ? 32'h8 : 32'h2);
        @(negedge clk);
        chk("drain_ov", 0, 32'(b4.out_valid), 32'h1);
        chk("drain_od", 0, b4.out_data,
            RR ? 32'h3333_0003 : 32'h2222_0002);

        step();
        setv(4'b0000);
        setr(1'b0);
        step();
        chk("mid_ov_pre", 0, 32'(b4.out_valid), 32'h1);
        setv(4'hF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rdy", 0, 32'(b4.in_ready), 32'h0);
        @(negedge clk);
        chk("mid_ov", 0, 32'(b4.out_valid), 32'h0);
        chk("mid_od", 0, b4.out_data, 32'h0);
        step();
        rst_n = 1'b1;
        setr(1'b1);
        @(negedge clk);
        chk("mid_ptr", 0, 32'(b4.in_ready), 32'h1);

        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < nch[i]; c++) begin
                    if (!vld[i][c] || acc[i][c]) begin
                        vld[i][c] = ($urandom_range(0, 2) != 0);
                        dat[i][c] = $urandom;
                    end
                end
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
